// File: rtl/ps2_dir_pkg.sv
// rtl/ps2_dir_pkg.sv - scan-code constants, decoder/direction enums and helpers for ps2_direction_decoder
package ps2_dir_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  typedef enum logic [2:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_NONE} dir_t;

  // Bit position of a direction inside the {up,down,left,right} bitmap.
  function automatic logic [3:0] dir_onehot(dir_t d);
    case (d)
      DIR_UP:    return 4'b1000;
      DIR_DOWN:  return 4'b0100;
      DIR_LEFT:  return 4'b0010;
      DIR_RIGHT: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  // Extended (E0-prefixed) arrow codes; anything else maps to DIR_NONE.
  function automatic dir_t arrow_dir(logic [7:0] b);
    case (b)
      SC_UP:    return DIR_UP;
      SC_DOWN:  return DIR_DOWN;
      SC_LEFT:  return DIR_LEFT;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

  // Plain W/S/A/D make codes; anything else maps to DIR_NONE.
  function automatic dir_t wasd_dir(logic [7:0] b);
    case (b)
      SC_W:    return DIR_UP;
      SC_S:    return DIR_DOWN;
      SC_A:    return DIR_LEFT;
      SC_D:    return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_arbiter.sv
// rtl/ps2_dir_arbiter.sv - fixed-priority fallback select (up>down>left>right) over the held bitmap
module ps2_dir_arbiter
  import ps2_dir_pkg::*;
(
  input  logic [3:0] held,
  output dir_t       fallback_dir
);

  // Pick the highest-priority key still held, or none.
  always_comb begin
    fallback_dir = DIR_NONE;
    if (held[3])      fallback_dir = DIR_UP;
    else if (held[2]) fallback_dir = DIR_DOWN;
    else if (held[1]) fallback_dir = DIR_LEFT;
    else if (held[0]) fallback_dir = DIR_RIGHT;
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 scan-code stream to last-pressed-wins direction levels; PS2_DIR_WASD_EN adds W/A/S/D keys
module ps2_direction_decoder
  import ps2_dir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held,
  output logic       dir_change,
  output logic       seq_error
);

  // The counter starts at 0 the cycle after a byte, so hitting this value
  // means TIMEOUT_CYCLES-1 idle cycles have elapsed in a prefix state.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  dec_state_t       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [3:0]       arrow_held;
  logic [3:0]       wasd_held;
  dir_t             last;

  dir_t       adir;
  dir_t       press_dir;
  logic       press;
  logic [3:0] arrow_nxt;
  logic [3:0] wasd_nxt;
  logic [3:0] held_nxt;
  dir_t       fallback;
  dir_t       last_nxt;
  logic [3:0] dirs_nxt;

  assign adir = arrow_dir(in_byte);
  assign held = arrow_held | wasd_held;

`ifdef PS2_DIR_WASD_EN
  dir_t wdir;
  assign wdir = wasd_dir(in_byte);
`endif

  // Key events carried by this byte: press/release per source bitmap.
  always_comb begin
    arrow_nxt = arrow_held;
    wasd_nxt  = wasd_held;
    press     = 1'b0;
    press_dir = DIR_NONE;
    if (in_valid) begin
      case (state)
        EXT: begin
          if (adir != DIR_NONE) begin
            arrow_nxt = arrow_held | dir_onehot(adir);
            press     = 1'b1;
            press_dir = adir;
          end
        end
        EXT_BRK: begin
          if (adir != DIR_NONE) arrow_nxt = arrow_held & ~dir_onehot(adir);
        end
`ifdef PS2_DIR_WASD_EN
        IDLE: begin
          if (wdir != DIR_NONE) begin
            wasd_nxt  = wasd_held | dir_onehot(wdir);
            press     = 1'b1;
            press_dir = wdir;
          end
        end
        BRK: begin
          if (wdir != DIR_NONE) wasd_nxt = wasd_held & ~dir_onehot(wdir);
        end
`endif
        default: ;
      endcase
    end
    held_nxt = arrow_nxt | wasd_nxt;
  end

  ps2_dir_arbiter u_arbiter (
    .held         (held_nxt),
    .fallback_dir (fallback)
  );

  // Last-pressed-wins; when the active key drops out, fall back by priority.
  always_comb begin
    last_nxt = last;
    if (press) begin
      last_nxt = press_dir;
    end else if (last != DIR_NONE && (held_nxt & dir_onehot(last)) == 4'b0000) begin
      last_nxt = fallback;
    end
    dirs_nxt = dir_onehot(last_nxt);
  end

  // Prefix decoder FSM, timeout counter, held state and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      arrow_held <= 4'b0000;
      wasd_held  <= 4'b0000;
      last       <= DIR_NONE;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      dir_change <= 1'b0;
      seq_error  <= 1'b0;
    end else begin
      arrow_held <= arrow_nxt;
      wasd_held  <= wasd_nxt;
      last       <= last_nxt;
      {up, down, left, right} <= dirs_nxt;
      dir_change <= (dirs_nxt != {up, down, left, right});
      seq_error  <= 1'b0;
      if (in_valid) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (in_byte == SC_EXT)      state <= EXT;
            else if (in_byte == SC_BRK) state <= BRK;
          end
          EXT: begin
            if (in_byte == SC_BRK) begin
              state <= EXT_BRK;
            end else if (in_byte == SC_EXT) begin
              state     <= EXT;
              seq_error <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          EXT_BRK: state <= IDLE;
          BRK:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state     <= IDLE;
          tmo_cnt   <= '0;
          seq_error <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - scoreboard bench for ps2_direction_decoder
module tb_ps2_direction_decoder;

  localparam int TMO = 16;

  logic       CLOCK_50;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       up, down, left, right;
  logic [3:0] held;
  logic       dir_change;
  logic       seq_error;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .held       (held),
    .dir_change (dir_change),
    .seq_error  (seq_error)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] dirs;
    logic [3:0] held;
    logic       dc;
    logic       se;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: state 0 idle, 1 ext, 2 brk, 3 ext_brk; key index 3=up..0=right
  int         m_state = 0;
  int         m_cnt   = 0;
  int         m_last  = -1;
  logic [3:0] m_arrow = 4'b0;
  logic [3:0] m_wasd  = 4'b0;
  logic [3:0] m_dirs  = 4'b0;

  function automatic int arrow_idx(input logic [7:0] b);
    case (b)
      8'h75: return 3;
      8'h72: return 2;
      8'h6B: return 1;
      8'h74: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_idx(input logic [7:0] b);
`ifdef PS2_DIR_WASD_EN
    case (b)
      8'h1D: return 3;
      8'h1B: return 2;
      8'h1C: return 1;
      8'h23: return 0;
      default: return -1;
    endcase
`else
    return (b == 8'hFF) ? -2 : -1;
`endif
  endfunction

  function automatic int top_held(input logic [3:0] h);
    for (int i = 3; i >= 0; i--) if (h[i]) return i;
    return -1;
  endfunction

  task automatic m_release(input int k, input bit wasd_src);
    logic [3:0] h;
    if (wasd_src) m_wasd[k] = 1'b0;
    else          m_arrow[k] = 1'b0;
    h = m_arrow | m_wasd;
    if (!h[k] && m_last == k) m_last = top_held(h);
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    exp_t       e;
    logic [3:0] one;
    logic [3:0] nd;
    bit         se;
    int         a, w;
    one = 4'b0001;
    se  = 1'b0;
    a   = arrow_idx(b);
    w   = wasd_idx(b);
    if (v) begin
      m_cnt = 0;
      case (m_state)
        0: begin
          if (b == 8'hE0) m_state = 1;
          else if (b == 8'hF0) m_state = 2;
          else if (w >= 0) begin m_wasd[w] = 1'b1; m_last = w; end
        end
        1: begin
          if (b == 8'hF0) m_state = 3;
          else if (b == 8'hE0) se = 1'b1;
          else begin
            if (a >= 0) begin m_arrow[a] = 1'b1; m_last = a; end
            m_state = 0;
          end
        end
        3: begin
          if (a >= 0) m_release(a, 1'b0);
          m_state = 0;
        end
        default: begin
          if (w >= 0) m_release(w, 1'b1);
          m_state = 0;
        end
      endcase
    end else if (m_state != 0) begin
      m_cnt++;
      if (m_cnt == TMO - 1) begin
        m_state = 0;
        m_cnt   = 0;
        se      = 1'b1;
      end
    end
    nd = (m_last < 0) ? 4'b0000 : (one << m_last);
    e.dirs = nd;
    e.held = m_arrow | m_wasd;
    e.dc   = (nd != m_dirs);
    e.se   = se;
    m_dirs = nd;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_last = -1;
    m_arrow = 4'b0; m_wasd = 4'b0; m_dirs = 4'b0;
  endtask

  // Drive one cycle of stimulus and queue the outcome expected after the edge.
  task automatic step(input bit v, input logic [7:0] b);
    in_valid = v;
    in_byte  = b;
    model_step(v, b);
    @(posedge CLOCK_50);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Compare DUT outputs against the oldest queued expectation after every edge.
  always @(posedge CLOCK_50) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("dirs", {up, down, left, right}, e.dirs);
      check_val("held", held, e.held);
      check_val("dir_change", dir_change, e.dc);
      check_val("seq_error", seq_error, e.se);
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_val("rst_dirs", {up, down, left, right}, 4'b0000);
    check_val("rst_held", held, 4'b0000);
    check_val("rst_dc", dir_change, 1'b0);
    check_val("rst_se", seq_error, 1'b0);
    reset = 1'b0;
    model_reset();
    idle(1);

    // single press of up
    send(8'hE0); send(8'h75); idle(2);
    // left overrides, release left falls back to up
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    // down and right held, release last then the other
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h72); idle(1);
    // timeout after a lone E0, then orphan 75 is ignored
    send(8'hE0); idle(TMO + 2); send(8'h75); idle(1);
    // timeout inside BRK and EXT_BRK
    send(8'hF0); idle(TMO);
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); idle(TMO); send(8'h74); idle(1);
    send(8'hE0); send(8'hF0); send(8'h74); idle(1);
    // non-extended break and non-arrow bytes
    send(8'hF0); send(8'h75); send(8'hAA); send(8'hFA); send(8'h1C); idle(1);
    send(8'hF0); send(8'h1C); idle(1);
    // double E0 prefix, then a valid arrow
    send(8'hE0); send(8'hE0); send(8'h75); idle(1);
    // release of a key not held, typematic repeat re-selects down
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h72); send(8'hE0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
`ifdef PS2_DIR_WASD_EN
    // arrow and WASD share the left direction
    send(8'hE0); send(8'h6B); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
    send(8'hF0); send(8'h1C); idle(1);
`endif
    // async reset while in EXT_BRK with right held
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_dirs", {up, down, left, right}, 4'b0000);
    check_val("arst_held", held, 4'b0000);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    send(8'h74); idle(2);

    repeat (3) @(posedge CLOCK_50);
    #2;
    check_val("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
